mcu_dmi_core_req_ctrl: RTL and testbench
========================================

// Module: mcu_dmi_core_req_ctrl
// PURPOSE
//  Core-clock DMI request controller that sits directly downstream of the JTAG-to-core pulse synchronizer.
//  - Consumes the single-cycle reg_en/reg_wr_en pulses.
//  - Captures the JTAG-held address/write-data.
//  - Issues one valid/ready request to the debug module, then waits for its response.
//  - Returns read data plus RISC-V DMI op status to the JTAG side, which samples them quasi-statically.
// PARAMETERS
//  ADDR_W          7    DMI address width
//  DATA_W          32   DMI data width
//  TIMEOUT_CYCLES  255  max cycles in REQ+RSP before abort (only with MCU_DMI_REQ_TIMEOUT_EN); legal range 1..65535
// PORTS
//  clk            in   1       core clock
//  rst_n          in   1       async active-low reset
//  reg_en         in   1       1-cycle access pulse from synchronizer
//  reg_wr_en      in   1       1-cycle write qualifier (valid only with reg_en)
//  jtag_addr      in   ADDR_W  address, stable from >=2 clk before reg_en until op ends
//  jtag_wdata     in   DATA_W  write data, same stability as jtag_addr
//  clr_status     in   1       synchronized dmireset pulse; clears sticky status
//  dm_req_valid   out  1       request valid to debug module
//  dm_req_ready   in   1       debug module accepts request
//  dm_req_write   out  1       1=write, 0=read
//  dm_req_addr    out  ADDR_W  captured address
//  dm_req_wdata   out  DATA_W  captured write data
//  dm_rsp_valid   in   1       1-cycle response strobe
//  dm_rsp_err     in   1       response error, qualified by dm_rsp_valid
//  dm_rsp_rdata   in   DATA_W  read data, qualified by dm_rsp_valid
//  rd_data        out  DATA_W  last successful read data, held stable
//  op_status      out  2       0=OK, 2=FAILED, 3=BUSY; 1 never driven
//  busy           out  1       high while FSM != IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; FSM=IDLE; timeout counter=0.
//  FSM states: IDLE, REQ, RSP.
//  IDLE:
//   - reg_en=1 and op_status==0: capture addr/wdata/reg_wr_en into dm_req_* regs.
//   - Next cycle: dm_req_valid=1, busy=1, state=REQ. Latency pulse->valid = 1 clk.
//   - reg_en=1 with op_status!=0 (sticky): request dropped, no state change.
//  REQ:
//   - Hold dm_req_valid and dm_req_* stable until dm_req_ready=1.
//   - On that cycle the handshake completes; next cycle valid=0, state=RSP.
//  RSP:
//   - On dm_rsp_valid:
//     - Reads with err=0: rd_data<=dm_rsp_rdata.
//     - Writes: rd_data unchanged.
//     - op_status<=err?2:0.
//   - Next cycle: state=IDLE, busy=0.
//  dm_rsp_valid in IDLE or REQ is ignored; this covers late responses after an abort.
//  reg_en while busy: request dropped; op_status<=3, sticky. The in-flight op continues.
//   - Its completion does not overwrite a 3.
//   - A concurrent err makes it stay 3.
//  Status 2 and 3 are sticky until clr_status=1, which forces op_status<=0 next cycle.
//  clr_status and reg_en in the same IDLE cycle: clear wins and the request is accepted.
//  clr_status while busy clears status only; the transaction proceeds.
//  Async reset mid-operation returns to IDLE immediately, drops dm_req_valid, and discards any pending response.
// CONFIGURATION
//  MCU_DMI_REQ_TIMEOUT_EN defined:
//   - A 16-bit counter clears on entry to REQ and increments each cycle in REQ/RSP.
//   - When the count reaches TIMEOUT_CYCLES without completion: op_status<=2 (3 kept if already 3), dm_req_valid<=0, state<=IDLE.
//   - Timeout and dm_rsp_valid in the same cycle: the response wins.
//  Not defined: no counter; the FSM waits indefinitely in REQ/RSP.
// TESTING
//  1. Read: addr=0x11, ready same cycle as valid, rsp 3 clk later with rdata=0xDEADBEEF, err=0 -> valid high exactly 1 clk, rd_data=0xDEADBEEF, op_status=0, busy drops.
//  2. Write: addr=0x04, wdata=0x1, ready held low 5 clk -> valid and addr/wdata stable for 6 clk, dm_req_write=1, rd_data unchanged.
//  3. Overrun: second reg_en 2 clk after first -> op_status=3 after first completes; next reg_en ignored; clr_status -> op_status=0, next read accepted.
//  4. Error: rsp err=1 -> op_status=2, rd_data unchanged, subsequent reg_en ignored until clr_status.
//  5. Timeout (macro on, TIMEOUT_CYCLES=8): no rsp -> busy for 8 clk, then op_status=2 and IDLE; a late dm_rsp_valid is ignored.
//  6. Reset: assert rst_n=0 while in RSP -> all outputs 0 asynchronously; after release, a new read completes normally.

Source files
------------

// File: rtl/mcu_dmi_core_req_ctrl.sv
// Core-clock DMI request controller: turns synchronized JTAG access pulses into one DM request
// and returns read data and op status. Optional timeout abort under MCU_DMI_REQ_TIMEOUT_EN.
module mcu_dmi_core_req_ctrl #(
    parameter int unsigned ADDR_W         = 7,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_en,
    input  logic              reg_wr_en,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic [DATA_W-1:0] jtag_wdata,
    input  logic              clr_status,
    output logic              dm_req_valid,
    input  logic              dm_req_ready,
    output logic              dm_req_write,
    output logic [ADDR_W-1:0] dm_req_addr,
    output logic [DATA_W-1:0] dm_req_wdata,
    input  logic              dm_rsp_valid,
    input  logic              dm_rsp_err,
    input  logic [DATA_W-1:0] dm_rsp_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        op_status,
    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRsp
    } state_e;

    localparam logic [1:0] StatusOk     = 2'd0;
    localparam logic [1:0] StatusFailed = 2'd2;
    localparam logic [1:0] StatusBusy   = 2'd3;

    state_e     state_q;
    logic       accept;
    logic       complete;
    logic       overrun;
    logic       timeout;
    logic [1:0] status_d;

    // A pending clear in the same cycle lets a request through despite sticky status.
    assign accept   = (state_q == StIdle) && reg_en && ((op_status == StatusOk) || clr_status);
    assign complete = (state_q == StRsp) && dm_rsp_valid;
    assign overrun  = (state_q != StIdle) && reg_en;

`ifdef MCU_DMI_REQ_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_q;

    // Response completion beats a timeout landing in the same cycle.
    assign timeout = (state_q != StIdle) && !complete && (tmo_cnt_q == TimeoutLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (accept) begin
            tmo_cnt_q <= '0;
        end else if (state_q != StIdle) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        status_d = op_status;
        if (clr_status) begin
            status_d = StatusOk;
        end else if (overrun) begin
            status_d = StatusBusy;
        end else if ((complete || timeout) && (op_status != StatusBusy)) begin
            status_d = (timeout || dm_rsp_err) ? StatusFailed : StatusOk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            dm_req_valid <= 1'b0;
            dm_req_write <= 1'b0;
            dm_req_addr  <= '0;
            dm_req_wdata <= '0;
            rd_data      <= '0;
            op_status    <= StatusOk;
            busy         <= 1'b0;
        end else begin
            op_status <= status_d;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        dm_req_addr  <= jtag_addr;
                        dm_req_wdata <= jtag_wdata;
                        dm_req_write <= reg_wr_en;
                        dm_req_valid <= 1'b1;
                        busy         <= 1'b1;
                        state_q      <= StReq;
                    end
                end
                StReq: begin
                    if (timeout) begin
                        dm_req_valid <= 1'b0;
                        busy         <= 1'b0;
                        state_q      <= StIdle;
                    end else if (dm_req_ready) begin
                        dm_req_valid <= 1'b0;
                        state_q      <= StRsp;
                    end
                end
                StRsp: begin
                    if (complete) begin
                        if (!dm_req_write && !dm_rsp_err) begin
                            rd_data <= dm_rsp_rdata;
                        end
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (timeout) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    dm_req_valid <= 1'b0;
                    busy         <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_dmi_core_req_ctrl.sv
// Directed bench for mcu_dmi_core_req_ctrl; timeout steps run only with MCU_DMI_REQ_TIMEOUT_EN.
module tb_mcu_dmi_core_req_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_en;
    logic        reg_wr_en;
    logic [6:0]  jtag_addr;
    logic [31:0] jtag_wdata;
    logic        clr_status;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic        dm_req_write;
    logic [6:0]  dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic        dm_rsp_valid;
    logic        dm_rsp_err;
    logic [31:0] dm_rsp_rdata;
    logic [31:0] rd_data;
    logic [1:0]  op_status;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mcu_dmi_core_req_ctrl #(
        .ADDR_W        (7),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_en       (reg_en),
        .reg_wr_en    (reg_wr_en),
        .jtag_addr    (jtag_addr),
        .jtag_wdata   (jtag_wdata),
        .clr_status   (clr_status),
        .dm_req_valid (dm_req_valid),
        .dm_req_ready (dm_req_ready),
        .dm_req_write (dm_req_write),
        .dm_req_addr  (dm_req_addr),
        .dm_req_wdata (dm_req_wdata),
        .dm_rsp_valid (dm_rsp_valid),
        .dm_rsp_err   (dm_rsp_err),
        .dm_rsp_rdata (dm_rsp_rdata),
        .rd_data      (rd_data),
        .op_status    (op_status),
        .busy         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle access pulse; returns one cycle after the capture edge.
    task automatic pulse(input logic wr, input logic [6:0] addr, input logic [31:0] wdata);
        reg_en     = 1'b1;
        reg_wr_en  = wr;
        jtag_addr  = addr;
        jtag_wdata = wdata;
        tick();
        reg_en    = 1'b0;
        reg_wr_en = 1'b0;
    endtask

    task automatic respond(input logic err, input logic [31:0] rdata);
        dm_rsp_valid = 1'b1;
        dm_rsp_err   = err;
        dm_rsp_rdata = rdata;
        tick();
        dm_rsp_valid = 1'b0;
        dm_rsp_err   = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        reg_en       = 1'b0;
        reg_wr_en    = 1'b0;
        jtag_addr    = '0;
        jtag_wdata   = '0;
        clr_status   = 1'b0;
        dm_req_ready = 1'b0;
        dm_rsp_valid = 1'b0;
        dm_rsp_err   = 1'b0;
        dm_rsp_rdata = '0;
        #3;
        chk("reset_valid", 32'(dm_req_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_status", 32'(op_status), 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Read with ready in the same cycle as valid.
        pulse(1'b0, 7'h11, 32'h0);
        dm_req_ready = 1'b1;
        chk("rd_valid", 32'(dm_req_valid), 32'd1);
        chk("rd_addr", 32'(dm_req_addr), 32'h11);
        chk("rd_write", 32'(dm_req_write), 32'd0);
        chk("rd_busy", 32'(busy), 32'd1);
        tick();
        dm_req_ready = 1'b0;
        chk("rd_valid_1clk", 32'(dm_req_valid), 32'd0);
        tick();
        tick();
        respond(1'b0, 32'hDEADBEEF);
        chk("rd_data", rd_data, 32'hDEADBEEF);
        chk("rd_status", 32'(op_status), 32'd0);
        chk("rd_busy_drop", 32'(busy), 32'd0);

        // Write with ready held low for five cycles.
        pulse(1'b1, 7'h04, 32'h1);
        for (int i = 0; i < 5; i++) begin
            chk("wr_valid_hold", 32'(dm_req_valid), 32'd1);
            chk("wr_addr_hold", 32'(dm_req_addr), 32'h04);
            chk("wr_wdata_hold", dm_req_wdata, 32'h1);
            tick();
        end
        dm_req_ready = 1'b1;
        chk("wr_valid_6th", 32'(dm_req_valid), 32'd1);
        chk("wr_write", 32'(dm_req_write), 32'd1);
        tick();
        dm_req_ready = 1'b0;
        chk("wr_valid_drop", 32'(dm_req_valid), 32'd0);
        respond(1'b0, 32'h55);
        chk("wr_rd_data_kept", rd_data, 32'hDEADBEEF);
        chk("wr_status", 32'(op_status), 32'd0);

        // Overrun: second pulse two cycles after the first.
        pulse(1'b0, 7'h22, 32'h0);
        dm_req_ready = 1'b1;
        tick();
        dm_req_ready = 1'b0;
        pulse(1'b0, 7'h23, 32'h0);
        respond(1'b0, 32'hCAFEF00D);
        chk("ovr_status", 32'(op_status), 32'd3);
        chk("ovr_busy", 32'(busy), 32'd0);
        chk("ovr_rd_data", rd_data, 32'hCAFEF00D);
        pulse(1'b0, 7'h24, 32'h0);
        chk("ovr_drop_valid", 32'(dm_req_valid), 32'd0);
        chk("ovr_drop_busy", 32'(busy), 32'd0);
        chk("ovr_sticky", 32'(op_status), 32'd3);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("ovr_cleared", 32'(op_status), 32'd0);
        pulse(1'b0, 7'h33, 32'h0);
        chk("ovr_next_valid", 32'(dm_req_valid), 32'd1);
        chk("ovr_next_addr", 32'(dm_req_addr), 32'h33);
        dm_req_ready = 1'b1;
        tick();
        dm_req_ready = 1'b0;
        respond(1'b0, 32'h12345678);
        chk("ovr_next_rd", rd_data, 32'h12345678);

        // Error response, then clear and accept in the same cycle.
        pulse(1'b0, 7'h10, 32'h0);
        dm_req_ready = 1'b1;
        tick();
        dm_req_ready = 1'b0;
        respond(1'b1, 32'h00000BAD);
        chk("err_status", 32'(op_status), 32'd2);
        chk("err_rd_kept", rd_data, 32'h12345678);
        pulse(1'b0, 7'h12, 32'h0);
        chk("err_drop_busy", 32'(busy), 32'd0);
        chk("err_sticky", 32'(op_status), 32'd2);
        clr_status = 1'b1;
        pulse(1'b0, 7'h13, 32'h0);
        clr_status = 1'b0;
        chk("clr_accept_status", 32'(op_status), 32'd0);
        chk("clr_accept_valid", 32'(dm_req_valid), 32'd1);
        dm_req_ready = 1'b1;
        tick();
        dm_req_ready = 1'b0;
        respond(1'b0, 32'hA5A5A5A5);
        chk("clr_accept_rd", rd_data, 32'hA5A5A5A5);

`ifdef MCU_DMI_REQ_TIMEOUT_EN
        // No ready ever: busy for exactly eight cycles, then abort.
        pulse(1'b0, 7'h20, 32'h0);
        for (int i = 0; i < 8; i++) begin
            chk("tmo_busy", 32'(busy), 32'd1);
            tick();
        end
        chk("tmo_idle", 32'(busy), 32'd0);
        chk("tmo_valid", 32'(dm_req_valid), 32'd0);
        chk("tmo_status", 32'(op_status), 32'd2);
        respond(1'b0, 32'h77777777);
        chk("tmo_late_rd", rd_data, 32'hA5A5A5A5);
        chk("tmo_late_status", 32'(op_status), 32'd2);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
`endif

        // Asynchronous reset while waiting for a response.
        pulse(1'b0, 7'h30, 32'h0);
        dm_req_ready = 1'b1;
        tick();
        dm_req_ready = 1'b0;
        chk("rst_pre_busy", 32'(busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_rd", rd_data, 32'd0);
        chk("rst_async_addr", 32'(dm_req_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse(1'b0, 7'h31, 32'h0);
        chk("rst_new_valid", 32'(dm_req_valid), 32'd1);
        dm_req_ready = 1'b1;
        tick();
        dm_req_ready = 1'b0;
        tick();
        respond(1'b0, 32'h0BADF00D);
        chk("rst_new_rd", rd_data, 32'h0BADF00D);
        chk("rst_new_status", 32'(op_status), 32'd0);
        chk("rst_new_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
